crc_job_arb: RTL and testbench
==============================

CRC_JOB_ARB -- requirements
Module: crc_job_arb

Interface
REQ-001 The block SHALL have parameter pTIMEOUT, default 255, range 2..65535: number of WAIT cycles allowed for a completion before the job is abandoned.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with the ports below.
- clk_1  input  1  sole clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req0, req1  input  1 each  requester job request; level; held until granted.
- req0_message, req1_message  input  60 each  requester payload.
- req0_mode, req1_mode  input  1 each  requester mode bit.
- req0_CRC, req1_CRC  input  1 each  requester CRC-select bit.
- gnt0, gnt1  output  1 each  one-cycle grant pulse to the owning requester.
- in_valid  output  1  one-cycle issue pulse to the CRC datapath.
- message  output  60  issued payload.
- mode  output  1  issued mode.
- CRC  output  1  issued CRC-select bit.
- done  input  1  completion pulse from the datapath, already synchronised into clk_1.
- resp_valid  output  1  one-cycle job-finished pulse.
- resp_id  output  1  owner of the finished job (0/1).
- resp_timeout  output  1  qualifies resp_valid: 1 = abandoned, 0 = completed.
- busy  output  1  high whenever state != IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with one job in flight at most.
REQ-004 In IDLE with req0 or req1 high, the block SHALL capture the winner's message/mode/CRC and id into the issue register and enter ISSUE next cycle; with no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request high, that requester wins.
REQ-006 In ISSUE (exactly one cycle) in_valid and the winner's gnt SHALL be 1; the next state SHALL be WAIT.
REQ-007 message/mode/CRC SHALL be registered, change only on the IDLE->ISSUE capture, and hold their value at all other times.
REQ-008 The WAIT counter SHALL be 16 bits and cleared to 0 on entry to WAIT.
REQ-009 Each WAIT cycle with done=1 SHALL move to RESP with the timeout flag cleared.
REQ-010 Each WAIT cycle with done=0 and counter==pTIMEOUT-1 SHALL move to RESP with the timeout flag set.
REQ-011 Each WAIT cycle with done=0 and counter<pTIMEOUT-1 SHALL increment the counter and stay in WAIT.
REQ-012 When done=1 and counter==pTIMEOUT-1 in the same cycle, done SHALL win: resp_timeout=0.
REQ-013 In RESP (exactly one cycle) resp_valid SHALL be 1, resp_id SHALL equal the job owner, resp_timeout SHALL equal the flag, and the next state SHALL be IDLE.
REQ-014 done SHALL be ignored in IDLE, ISSUE and RESP; a late done after a timeout SHALL have no effect.
REQ-015 Requests SHALL be sampled only in IDLE, so the minimum job-to-job spacing is IDLE, ISSUE, WAIT(>=1), RESP, i.e. 4 cycles.
REQ-016 The last-granted pointer SHALL update on every grant, including jobs that later time out.
REQ-017 gnt0 and gnt1 SHALL never be high together; in_valid SHALL equal gnt0|gnt1.
REQ-018 All outputs SHALL be driven directly from flops or from state decode, with no combinational path from inputs to outputs.

Reset
REQ-019 Asserting rst_n=0 SHALL, asynchronously and in any state including mid-job, force IDLE, counter=0, timeout flag=0, last-granted=1 (so req0 wins first), and issue register=0.
REQ-020 During and after reset, all outputs (gnt0, gnt1, in_valid, message, mode, CRC, resp_valid, resp_id, resp_timeout, busy) SHALL be 0 until the first post-reset transition.
REQ-021 A job in flight at reset SHALL be dropped with no resp_valid.

Verification
REQ-022 The bench SHALL cover single request: req1=1, req1_message=60'h0ABC, done 5 cycles after in_valid -> gnt1 and in_valid high together, message=60'h0ABC, resp_valid with resp_id=1, resp_timeout=0.
REQ-023 The bench SHALL cover contention: req0 and req1 held high after reset -> grants alternate gnt0, gnt1, gnt0, with done returned for each job.
REQ-024 The bench SHALL cover timeout: pTIMEOUT=8, no done -> resp_valid with resp_timeout=1 exactly 8 WAIT cycles after ISSUE; a done 3 cycles later produces no response.
REQ-025 The bench SHALL cover the boundary: done coincides with the last WAIT cycle -> resp_timeout=0.
REQ-026 The bench SHALL cover reset mid-job: rst_n low during WAIT -> busy=0 and all outputs 0 immediately; no resp_valid; the next request with both requesters high is granted to req0.
REQ-027 The bench SHALL cover stray done: done pulses while IDLE -> no state change and no resp_valid.

Source files
------------

// File: rtl/crc_job_arb.sv
// Round-robin arbiter that issues one CRC job at a time to the datapath.
// Ports:
//   clk_1, rst_n           : clock, async active-low reset
//   reqN, reqN_message/
//   reqN_mode/reqN_CRC     : requester level request and job payload
//   gntN, in_valid         : one-cycle grant and issue pulses
//   message, mode, CRC     : registered job payload to the datapath
//   done                   : datapath completion pulse
//   resp_valid, resp_id,
//   resp_timeout           : one-cycle job-finished report
//   busy                   : a job is in flight
module crc_job_arb #(
  parameter int unsigned pTIMEOUT = 255
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [59:0] req0_message,
  input  logic [59:0] req1_message,
  input  logic        req0_mode,
  input  logic        req1_mode,
  input  logic        req0_CRC,
  input  logic        req1_CRC,
  output logic        gnt0,
  output logic        gnt1,
  output logic        in_valid,
  output logic [59:0] message,
  output logic        mode,
  output logic        CRC,
  input  logic        done,
  output logic        resp_valid,
  output logic        resp_id,
  output logic        resp_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] LAST = 16'(pTIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [59:0] msg_q, msg_d;
  logic        mode_q, mode_d;
  logic        crc_q, crc_d;
  logic        win;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      msg_q   <= '0;
      mode_q  <= 1'b0;
      crc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      last_q  <= last_d;
      id_q    <= id_d;
      msg_q   <= msg_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    last_d  = last_q;
    id_d    = id_q;
    msg_d   = msg_q;
    mode_d  = mode_q;
    crc_d   = crc_q;
    // On contention the side not granted last wins.
    win     = (req0 && req1) ? ~last_q : req1;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          id_d    = win;
          last_d  = win;
          msg_d   = win ? req1_message : req0_message;
          mode_d  = win ? req1_mode : req0_mode;
          crc_d   = win ? req1_CRC : req0_CRC;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is checked first so it wins on the last cycle.
        if (done) begin
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == LAST) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_valid     = (state_q == S_ISSUE);
  assign gnt0         = in_valid & ~id_q;
  assign gnt1         = in_valid & id_q;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_id      = resp_valid & id_q;
  assign resp_timeout = resp_valid & to_q;
  assign busy         = (state_q != S_IDLE);
  assign message      = msg_q;
  assign mode         = mode_q;
  assign CRC          = crc_q;

endmodule

// File: tb/tb_crc_job_arb.sv
// Randomised self-checking bench for crc_job_arb.
// Job-level model: winner by round-robin, response time by done delay.
module tb_crc_job_arb;

  localparam int T = 8;

  logic        clk_1 = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [59:0] req0_message, req1_message;
  logic        req0_mode, req1_mode;
  logic        req0_CRC, req1_CRC;
  logic        gnt0, gnt1, in_valid;
  logic [59:0] message;
  logic        mode, CRC;
  logic        done;
  logic        resp_valid, resp_id, resp_timeout, busy;

  int errors = 0;
  int checks = 0;
  logic last_m = 1'b1;

  crc_job_arb #(.pTIMEOUT(T)) dut (
    .clk_1(clk_1), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .req0_message(req0_message), .req1_message(req1_message),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_CRC(req0_CRC), .req1_CRC(req1_CRC),
    .gnt0(gnt0), .gnt1(gnt1), .in_valid(in_valid),
    .message(message), .mode(mode), .CRC(CRC),
    .done(done),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  always #5 clk_1 = ~clk_1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // One job: d = done delay in cycles after in_valid (0 = never).
  task automatic run_job(input logic r0, input logic r1,
                         input logic [59:0] m0, input logic [59:0] m1,
                         input logic md0, input logic md1,
                         input logic c0, input logic c1,
                         input int d, input bit hold);
    logic        w, eto;
    logic [61:0] ep;
    int          exp_c, end_c;
    bit          seen;
    w      = (r0 && r1) ? ~last_m : r1;
    last_m = w;
    ep     = w ? {m1, md1, c1} : {m0, md0, c0};
    if (d >= 1 && d <= T) begin
      exp_c = d + 1; eto = 1'b0;
    end else begin
      exp_c = T + 1; eto = 1'b1;
    end
    end_c = (d > exp_c) ? d + 1 : exp_c;
    req0 = r0; req1 = r1;
    req0_message = m0; req1_message = m1;
    req0_mode = md0; req1_mode = md1;
    req0_CRC = c0; req1_CRC = c1;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk_1);
      seen = (in_valid === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL issue_wait: in_valid=%b required 1", in_valid);
      req0 = 0; req1 = 0;
      return;
    end
    checks++;
    if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: gnt1,gnt0=%b%b required %b", gnt1, gnt0,
               w ? 2'b10 : 2'b01);
    end
    checks++;
    if ({message, mode, CRC} !== ep) begin
      errors++;
      $display("FAIL payload: got %h required %h", {message, mode, CRC}, ep);
    end
    if (!hold) begin
      req0 = 0; req1 = 0;
    end
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk_1);
      checks++;
      if (resp_valid !== (c == exp_c)) begin
        errors++;
        $display("FAIL resp_valid c=%0d: got %b required %b",
                 c, resp_valid, c == exp_c);
      end
      checks++;
      if (busy !== (c <= exp_c) || in_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy c=%0d: busy=%b in_valid=%b required %b,0",
                 c, busy, in_valid, c <= exp_c);
      end
      checks++;
      if ({message, mode, CRC} !== ep) begin
        errors++;
        $display("FAIL payload_hold c=%0d: got %h required %h",
                 c, {message, mode, CRC}, ep);
      end
      if (c == exp_c) begin
        checks++;
        if ({resp_id, resp_timeout} !== {w, eto}) begin
          errors++;
          $display("FAIL resp_info: id,to=%b%b required %b%b",
                   resp_id, resp_timeout, w, eto);
        end
      end
      done = (c == d);
    end
    done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; req0 = 0; req1 = 0; done = 0;
    req0_message = '0; req1_message = '0;
    req0_mode = 0; req1_mode = 0; req0_CRC = 0; req1_CRC = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, in_valid, message, mode, CRC, resp_valid,
         resp_id, resp_timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b msg=%h required 0", busy, message);
    end
    repeat (2) @(negedge clk_1);
    rst_n = 1;
    @(negedge clk_1);
    checks++;
    if ({gnt0, gnt1, in_valid, message, mode, CRC, resp_valid,
         resp_id, resp_timeout, busy} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b msg=%h required 0", busy, message);
    end
    last_m = 1'b1;
  endtask

  task automatic test_contention();
    for (int j = 0; j < 3; j++)
      run_job(1, 1, 60'h111 + 60'(j), 60'h222 + 60'(j),
              1'(j), 1'(~j), 1, 0, 2 + j, 1);
    req0 = 0; req1 = 0;
  endtask

  task automatic test_single();
    run_job(0, 1, 60'h0FFF, 60'h0ABC, 0, 1, 0, 1, 5, 0);
  endtask

  task automatic test_timeout();
    run_job(1, 0, 60'h0DEAD, 60'h0BEEF, 1, 0, 1, 0, T + 4, 0);
  endtask

  task automatic test_boundary();
    run_job(0, 1, 60'h5A5, 60'hA5A, 0, 0, 1, 1, T, 0);
  endtask

  task automatic test_stray_done();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_1);
      done = c[0];
      checks++;
      if ({resp_valid, busy, in_valid} !== 3'b000) begin
        errors++;
        $display("FAIL stray_done c=%0d: rv,busy,iv=%b%b%b required 000",
                 c, resp_valid, busy, in_valid);
      end
    end
    done = 0;
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    req0 = 1; req0_message = 60'h777;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk_1);
      seen = (in_valid === 1'b1);
    end
    req0 = 0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_issue: in_valid=%b required 1", in_valid);
    end
    repeat (3) @(negedge clk_1);
    rst_n = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, in_valid, message, mode, CRC, resp_valid,
         resp_id, resp_timeout, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b msg=%h required 0", busy, message);
    end
    last_m = 1'b1;
    @(negedge clk_1);
    rst_n = 1;
    for (int c = 0; c < T + 4; c++) begin
      @(negedge clk_1);
      done = (c == 2);
      checks++;
      if ({resp_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL dropped_job c=%0d: rv,busy=%b%b required 00",
                 c, resp_valid, busy);
      end
    end
    done = 0;
    run_job(1, 1, 60'h123, 60'h456, 1, 1, 0, 0, 3, 0);
  endtask

  task automatic test_random();
    logic [1:0] p;
    for (int j = 0; j < 25; j++) begin
      p = 2'($urandom_range(1, 3));
      run_job(p[0], p[1],
              60'({$urandom(), $urandom()}), 60'({$urandom(), $urandom()}),
              1'($urandom()), 1'($urandom()),
              1'($urandom()), 1'($urandom()),
              int'($urandom_range(0, T + 3)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_boundary();
    test_stray_done();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
